// File: rtl/isa_decode_mc.sv
// isa_decode_mc: multi-channel TRIG/STEP/WAIT/QWAIT instruction decoder with TRIG forwarding queue
// Ports:
//   I_clk, I_rst_n          clock, synchronous active-low reset
//   I_isa_valid/O_isa_ready instruction handshake, payload I_isa_addr/I_isa_data/I_isa_mask
//   O_trig                  one-cycle TRIG pulse per channel
//   O_trig_num/O_trig_step  last TRIG/STEP payload per channel, channel c at [32c+31:32c]
//   O_wait                  per-channel saturating accumulated wait
//   O_tx_data/O_tx_valid    FWFT queue head {addr,data} of forwarded TRIGs, popped by I_tx_ready
//   O_busy                  QWAIT stall in progress
//   O_err_cnt               saturating count of rejected instructions
module isa_decode_mc #(
  parameter int          NUM_CH         = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
  parameter int          CH_STRIDE_LOG2 = 12,
  parameter int          TX_DEPTH       = 8,
  parameter int          ERR_W          = 16
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_isa_valid,
  output logic                   O_isa_ready,
  input  logic [31:0]            I_isa_addr,
  input  logic [31:0]            I_isa_data,
  input  logic [3:0]             I_isa_mask,
  output logic [NUM_CH-1:0]      O_trig,
  output logic [32*NUM_CH-1:0]   O_trig_num,
  output logic [32*NUM_CH-1:0]   O_trig_step,
  output logic [32*NUM_CH-1:0]   O_wait,
  output logic [63:0]            O_tx_data,
  output logic                   O_tx_valid,
  input  logic                   I_tx_ready,
  output logic                   O_busy,
  output logic [ERR_W-1:0]       O_err_cnt
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] REG_MASK = (32'd1 << CH_STRIDE_LOG2) - 32'd1;
  typedef enum logic {RUN, STALL} state_t;
  state_t state;
  logic [31:0] cnt;
  logic [63:0] mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] q_cnt;
  logic [31:0] off, ch, rg;
  logic [CW-1:0] ci;
  logic in_map, exec, xfer, push, pop, q_full;
  logic [32:0] wsum;
  always_comb begin
    off = I_isa_addr - BASE_ADDR;
    ch = off >> CH_STRIDE_LOG2;
    rg = off & REG_MASK;
    ci = ch[CW-1:0];
    in_map = rg == 32'h0 || rg == 32'h4 || rg == 32'h8 || rg == 32'hC || rg == 32'h10;
    exec = I_isa_mask == 4'hF && I_isa_addr >= BASE_ADDR && ch < 32'(NUM_CH) && in_map;
    xfer = I_isa_valid && O_isa_ready;
    push = xfer && exec && rg == 32'h0;
    pop = O_tx_valid && I_tx_ready;
    wsum = {1'b0, O_wait[ci*32 +: 32]} + {1'b0, I_isa_data};
  end
  // ready is a function of state only (plus reset hold), never of I_isa_valid
  assign q_full = q_cnt == (PW+1)'(TX_DEPTH);
  assign O_isa_ready = I_rst_n && state == RUN && !q_full;
  assign O_busy = state == STALL;
  assign O_tx_valid = q_cnt != '0;
  // stale entries left behind by a reset are masked by the empty count
  assign O_tx_data = O_tx_valid ? mem[rd_ptr] : 64'h0;
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state <= RUN;
      cnt <= '0;
      O_trig <= '0;
      O_trig_num <= '0;
      O_trig_step <= '0;
      O_wait <= '0;
      O_err_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt <= '0;
    end else begin
      O_trig <= '0;
      if (xfer && !exec && !(&O_err_cnt))
        O_err_cnt <= O_err_cnt + ERR_W'(1);
      if (xfer && exec) begin
        if (rg == 32'h0) begin
          O_trig[ci] <= 1'b1;
          O_trig_num[ci*32 +: 32] <= I_isa_data;
          O_wait[ci*32 +: 32] <= '0;
        end
        if (rg == 32'h4)
          O_trig_step[ci*32 +: 32] <= I_isa_data;
        if (rg == 32'h8)
          O_wait[ci*32 +: 32] <= '0;
        if (rg == 32'hC)
          O_wait[ci*32 +: 32] <= wsum[32] ? 32'hFFFF_FFFF : wsum[31:0];
        if (rg == 32'h10 && I_isa_data != 32'h0) begin
          state <= STALL;
          cnt <= I_isa_data;
        end
      end
      // the stall covers exactly cnt cycles: leave on the cycle cnt reaches 1
      if (state == STALL) begin
        cnt <= cnt - 32'd1;
        if (cnt == 32'd1)
          state <= RUN;
      end
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      q_cnt <= q_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge I_clk)
    if (push)
      mem[wr_ptr] <= {I_isa_addr, I_isa_data};
endmodule

// File: tb/tb_isa_decode_mc.sv
// tb_isa_decode_mc: table-driven and directed-sequence checks of isa_decode_mc
module tb_isa_decode_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic isa_valid = 1'b0;
  logic [31:0] isa_addr = '0;
  logic [31:0] isa_data = '0;
  logic [3:0] isa_mask = '0;
  logic tx_ready = 1'b0;
  logic isa_ready, tx_valid, busy;
  logic [3:0] trig;
  logic [127:0] trig_num, trig_step, wt;
  logic [63:0] tx_data;
  logic [15:0] err_cnt;
  logic s_isa_ready, s_tx_valid, s_busy;
  logic [3:0] s_trig;
  logic [127:0] s_trig_num, s_trig_step, s_wt;
  logic [63:0] s_tx_data;
  logic [2:0] s_err_cnt;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  isa_decode_mc dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_isa_valid(isa_valid), .O_isa_ready(isa_ready),
    .I_isa_addr(isa_addr), .I_isa_data(isa_data), .I_isa_mask(isa_mask),
    .O_trig(trig), .O_trig_num(trig_num), .O_trig_step(trig_step), .O_wait(wt),
    .O_tx_data(tx_data), .O_tx_valid(tx_valid), .I_tx_ready(tx_ready),
    .O_busy(busy), .O_err_cnt(err_cnt)
  );
  // narrow error counter instance to reach saturation quickly
  isa_decode_mc #(.ERR_W(3)) dut_s (
    .I_clk(clk), .I_rst_n(rst_n), .I_isa_valid(isa_valid), .O_isa_ready(s_isa_ready),
    .I_isa_addr(isa_addr), .I_isa_data(isa_data), .I_isa_mask(isa_mask),
    .O_trig(s_trig), .O_trig_num(s_trig_num), .O_trig_step(s_trig_step), .O_wait(s_wt),
    .O_tx_data(s_tx_data), .O_tx_valid(s_tx_valid), .I_tx_ready(tx_ready),
    .O_busy(s_busy), .O_err_cnt(s_err_cnt)
  );
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] mask;
    int ch;
    logic [3:0] trig;
    logic [31:0] num;
    logic [31:0] step;
    logic [31:0] wt;
    logic busy;
    logic txv;
    int err;
  } vec_t;
  vec_t tv[21];
  logic [63:0] qe[9];
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int t;
    t = 0;
    isa_addr = a;
    isa_data = d;
    isa_mask = m;
    isa_valid = 1'b1;
    @(negedge clk);
    while (!isa_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("accept_ready", isa_ready, 1);
    tick();
    isa_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lows;
    tv[0]  = '{32'h0200_2000, 32'h55,        4'hF, 2, 4'b0100, 32'h55,   32'h0,    32'h0,        1'b0, 1'b1, 0};
    tv[1]  = '{32'h0200_2004, 32'h1234,      4'hF, 2, 4'b0000, 32'h55,   32'h1234, 32'h0,        1'b0, 1'b0, 0};
    tv[2]  = '{32'h0200_200C, 32'h10,        4'hF, 2, 4'b0000, 32'h55,   32'h1234, 32'h10,       1'b0, 1'b0, 0};
    tv[3]  = '{32'h0200_2000, 32'h66,        4'hF, 2, 4'b0100, 32'h66,   32'h1234, 32'h0,        1'b0, 1'b1, 0};
    tv[4]  = '{32'h0200_000C, 32'hFFFF_FFF0, 4'hF, 0, 4'b0000, 32'h0,    32'h0,    32'hFFFF_FFF0, 1'b0, 1'b0, 0};
    tv[5]  = '{32'h0200_000C, 32'h20,        4'hF, 0, 4'b0000, 32'h0,    32'h0,    32'hFFFF_FFFF, 1'b0, 1'b0, 0};
    tv[6]  = '{32'h0200_100C, 32'h7,         4'hF, 1, 4'b0000, 32'h0,    32'h0,    32'h7,        1'b0, 1'b0, 0};
    tv[7]  = '{32'h0200_0008, 32'hDEAD,      4'hF, 0, 4'b0000, 32'h0,    32'h0,    32'h0,        1'b0, 1'b0, 0};
    tv[8]  = '{32'h0200_100C, 32'h1,         4'hF, 1, 4'b0000, 32'h0,    32'h0,    32'h8,        1'b0, 1'b0, 0};
    tv[9]  = '{32'h0200_0000, 32'hA5A5,      4'hF, 0, 4'b0001, 32'hA5A5, 32'h0,    32'h0,        1'b0, 1'b1, 0};
    tv[10] = '{32'h0200_3000, 32'h3,         4'hF, 3, 4'b1000, 32'h3,    32'h0,    32'h0,        1'b0, 1'b1, 0};
    tv[11] = '{32'h0200_1010, 32'h0,         4'hF, 1, 4'b0000, 32'h0,    32'h0,    32'h8,        1'b0, 1'b0, 0};
    tv[12] = '{32'h0200_2000, 32'h99,        4'h7, 2, 4'b0000, 32'h66,   32'h1234, 32'h0,        1'b0, 1'b0, 1};
    tv[13] = '{32'h0200_5000, 32'h99,        4'hF, 2, 4'b0000, 32'h66,   32'h1234, 32'h0,        1'b0, 1'b0, 2};
    tv[14] = '{32'h0100_0000, 32'h99,        4'hF, 0, 4'b0000, 32'hA5A5, 32'h0,    32'h0,        1'b0, 1'b0, 3};
    tv[15] = '{32'h0200_1020, 32'h5,         4'hF, 1, 4'b0000, 32'h0,    32'h0,    32'h8,        1'b0, 1'b0, 4};
    tv[16] = '{32'h0200_1014, 32'h5,         4'hF, 1, 4'b0000, 32'h0,    32'h0,    32'h8,        1'b0, 1'b0, 5};
    tv[17] = '{32'h0200_1002, 32'h5,         4'hF, 1, 4'b0000, 32'h0,    32'h0,    32'h8,        1'b0, 1'b0, 6};
    tv[18] = '{32'h0200_4000, 32'h5,         4'hF, 3, 4'b0000, 32'h3,    32'h0,    32'h0,        1'b0, 1'b0, 7};
    tv[19] = '{32'h0200_FFFC, 32'h5,         4'hF, 3, 4'b0000, 32'h3,    32'h0,    32'h0,        1'b0, 1'b0, 8};
    tv[20] = '{32'h0200_5010, 32'h3,         4'hF, 3, 4'b0000, 32'h3,    32'h0,    32'h0,        1'b0, 1'b0, 9};
    repeat (3) tick();
    chk("rst_ready_held", isa_ready, 0);
    chk("rst_trig_num", trig_num, 0);
    chk("rst_wait", wt, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready_rel", isa_ready, 1);
    chk("rst_busy", busy, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      issue(tv[i].addr, tv[i].data, tv[i].mask);
      chk($sformatf("v%0d_trig", i), trig, tv[i].trig);
      chk($sformatf("v%0d_num", i), trig_num[tv[i].ch*32 +: 32], tv[i].num);
      chk($sformatf("v%0d_step", i), trig_step[tv[i].ch*32 +: 32], tv[i].step);
      chk($sformatf("v%0d_wait", i), wt[tv[i].ch*32 +: 32], tv[i].wt);
      chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d_txv", i), tx_valid, tv[i].txv);
      if (tv[i].txv)
        chk($sformatf("v%0d_txdata", i), tx_data, {tv[i].addr, tv[i].data});
      chk($sformatf("v%0d_err", i), err_cnt, tv[i].err);
      chk($sformatf("v%0d_err_sat", i), s_err_cnt, tv[i].err > 7 ? 7 : tv[i].err);
    end
    // QWAIT 5 with valid held high: next instruction waits out exactly 5 cycles
    issue(32'h0200_0010, 32'h5, 4'hF);
    isa_valid = 1'b1;
    isa_addr = 32'h0200_1004;
    isa_data = 32'h77;
    lows = 0;
    while (!isa_ready && lows < 20) begin
      chk("qwait_busy", busy, 1);
      lows++;
      tick();
    end
    chk("qwait_stall_len", lows, 5);
    chk("qwait_busy_end", busy, 0);
    tick();
    isa_valid = 1'b0;
    chk("qwait_next_step", trig_step[63:32], 32'h77);
    // fill the queue with downstream stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      qe[i] = {32'h0200_0000 | (32'(i % 4) << 12), 32'h100 + 32'(i)};
      issue(qe[i][63:32], qe[i][31:0], 4'hF);
    end
    qe[8] = {32'h0200_1000, 32'h108};
    isa_addr = qe[8][63:32];
    isa_data = qe[8][31:0];
    isa_valid = 1'b1;
    @(negedge clk);
    chk("full_ready", isa_ready, 0);
    tick();
    chk("full_ready_hold", isa_ready, 0);
    chk("full_txv", tx_valid, 1);
    chk("full_head", tx_data, qe[0]);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("pop_ready", isa_ready, 1);
    chk("pop_head", tx_data, qe[1]);
    tick();
    isa_valid = 1'b0;
    tx_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      chk($sformatf("drain%0d_txv", k), tx_valid, 1);
      chk($sformatf("drain%0d_data", k), tx_data, qe[k]);
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid, 0);
    // simultaneous push and pop keeps the count
    issue(32'h0200_0000, 32'hA0, 4'hF);
    issue(32'h0200_1000, 32'hB0, 4'hF);
    tx_ready = 1'b1;
    issue(32'h0200_2000, 32'hC0, 4'hF);
    tx_ready = 1'b0;
    chk("pp_head_b", tx_data, {32'h0200_1000, 32'hB0});
    tx_ready = 1'b1;
    tick();
    chk("pp_txv_c", tx_valid, 1);
    chk("pp_head_c", tx_data, {32'h0200_2000, 32'hC0});
    tick();
    chk("pp_empty", tx_valid, 0);
    // reset in the middle of a stall with three queued entries
    tx_ready = 1'b0;
    issue(32'h0200_0000, 32'h1, 4'hF);
    issue(32'h0200_1000, 32'h2, 4'hF);
    issue(32'h0200_2000, 32'h3, 4'hF);
    issue(32'h0200_0010, 32'd10, 4'hF);
    tick();
    chk("r6_busy", busy, 1);
    chk("r6_ready", isa_ready, 0);
    chk("r6_txv", tx_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("r6_trig", trig, 0);
    chk("r6_num", trig_num, 0);
    chk("r6_step", trig_step, 0);
    chk("r6_wait", wt, 0);
    chk("r6_txv_rst", tx_valid, 0);
    chk("r6_txdata", tx_data, 0);
    chk("r6_busy_rst", busy, 0);
    chk("r6_err", err_cnt, 0);
    chk("r6_err_sat", s_err_cnt, 0);
    chk("r6_ready_held", isa_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("r6_ready_rel", isa_ready, 1);
    chk("r6_txv_rel", tx_valid, 0);
    chk("r6_busy_rel", busy, 0);
    issue(32'h0200_1000, 32'h7, 4'hF);
    chk("r6_new_trig", trig, 4'b0010);
    chk("r6_new_head", tx_data, {32'h0200_1000, 32'h7});
    chk("r6_new_num", trig_num, {32'h0, 32'h0, 32'h7, 32'h0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
